// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aud_pkg
// Brief    : Shared types and channel-mode encoding for aud_recorder_mc.
// Revision : 1.0
// ============================================================================
package aud_pkg;

  localparam logic [1:0] c_CH_LEFT   = 2'd0;
  localparam logic [1:0] c_CH_RIGHT  = 2'd1;
  localparam logic [1:0] c_CH_STEREO = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_REC   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } rec_state_e;

  typedef enum logic [1:0] {
    CH_LEFT   = c_CH_LEFT,
    CH_RIGHT  = c_CH_RIGHT,
    CH_STEREO = c_CH_STEREO
  } chan_mode_e;

  // The reserved encoding falls back to left-only capture.
  function automatic chan_mode_e decode_chan(input logic [1:0] chan);
    case (chan)
      c_CH_RIGHT:  return CH_RIGHT;
      c_CH_STEREO: return CH_STEREO;
      default:     return CH_LEFT;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_deser.sv
`default_nettype none
// ============================================================================
// Module   : i2s_deser
// Brief    : I2S slot deserialiser; one-bit delay after each LRC edge, MSB first.
// Revision : 1.0
// ============================================================================
module i2s_deser #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word,
  output logic              o_slot,
  output logic              o_frame
);

  localparam int                 c_CNT_W = $clog2(DATA_W);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

  logic               r_lrc_q;
  logic               r_active;
  logic               r_slot;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DATA_W-2:0]  r_sr;
  logic               w_edge;

  assign w_edge = i_lrc ^ r_lrc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lrc_q  <= 1'b0;
      r_active <= 1'b0;
      r_slot   <= 1'b0;
      r_cnt    <= '0;
      r_sr     <= '0;
    end else begin
      r_lrc_q <= i_lrc;
      // An edge restarts the slot, silently dropping any partial word.
      if (w_edge) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_slot   <= i_lrc;
      end else if (r_active) begin
        r_sr  <= o_word[DATA_W-2:0];
        r_cnt <= r_cnt + c_CNT_W'(1);
        if (r_cnt == c_LAST) begin
          r_active <= 1'b0;
        end
      end
    end
  end

  assign o_word       = {r_sr, i_data};
  assign o_word_valid = r_active & ~w_edge & (r_cnt == c_LAST);
  assign o_slot       = r_slot;
  assign o_frame      = w_edge & ~i_lrc;

endmodule
`default_nettype wire

// File: rtl/aud_recorder_mc.sv
`default_nettype none
// ============================================================================
// Module   : aud_recorder_mc
// Brief    : Multi-channel I2S capture engine issuing one-cycle SRAM write strobes.
// Revision : 1.0
// ============================================================================
module aud_recorder_mc
  import aud_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_chan,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W:0]   o_len,
  output logic              o_busy,
  output logic              o_done
);

  logic              w_word_valid;
  logic [DATA_W-1:0] w_word;
  logic              w_slot;
  logic              w_frame;

  i2s_deser #(.DATA_W(DATA_W)) u_deser (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lrc        (i_lrc),
    .i_data       (i_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_slot       (w_slot),
    .o_frame      (w_frame)
  );

  rec_state_e        r_state;
  chan_mode_e        r_mode;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_we;
  logic              r_stop_pend;
  logic              r_pause_pend;

  logic w_stop;
  logic w_pause;
  logic w_full;
  logic w_slot_en;
  logic w_accept;

  assign w_stop  = r_stop_pend | i_stop;
  assign w_pause = r_pause_pend | i_pause;
  // The pointer's extra MSB doubles as the memory-full flag.
  assign w_full  = r_ptr[ADDR_W];

  always_comb begin
    w_slot_en = 1'b0;
    case (r_mode)
      CH_RIGHT:  w_slot_en = w_slot;
      CH_STEREO: w_slot_en = 1'b1;
      default:   w_slot_en = ~w_slot;
    endcase
  end

  assign w_accept = w_word_valid & w_slot_en & ~w_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= CH_LEFT;
      r_ptr        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_pause_pend <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state      <= ST_ARM;
            r_ptr        <= '0;
            r_mode       <= decode_chan(i_chan);
            r_stop_pend  <= 1'b0;
            r_pause_pend <= 1'b0;
          end
        end
        ST_ARM: begin
          if (w_frame) begin
            r_state      <= w_stop ? ST_DONE : (w_pause ? ST_PAUSE : ST_REC);
            r_stop_pend  <= 1'b0;
            r_pause_pend <= 1'b0;
          end else begin
            r_stop_pend  <= w_stop;
            r_pause_pend <= w_pause;
          end
        end
        ST_REC: begin
          if (w_full || (w_frame && (w_stop || w_pause))) begin
            r_state      <= (w_full || w_stop) ? ST_DONE : ST_PAUSE;
            r_stop_pend  <= 1'b0;
            r_pause_pend <= 1'b0;
          end else begin
            r_stop_pend  <= w_stop;
            r_pause_pend <= w_pause;
            if (w_accept) begin
              r_we   <= 1'b1;
              r_addr <= r_ptr[ADDR_W-1:0];
              r_data <= w_word;
              r_ptr  <= r_ptr + (ADDR_W+1)'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (i_stop) begin
            r_state <= ST_DONE;
          end else if (i_start) begin
            r_state <= ST_ARM;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_we      = r_we;
  assign o_address = r_addr;
  assign o_data    = r_data;
  assign o_len     = r_ptr;
  assign o_busy    = (r_state == ST_ARM) || (r_state == ST_REC);
  assign o_done    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_aud_recorder_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_recorder_mc
// Brief    : Directed and randomized bench with a frame-level recorder model.
// Revision : 1.0
// ============================================================================
module tb_aud_recorder_mc;

  localparam int DW = 16;
  localparam int AW = 3;

  localparam logic [3:0] R_NONE  = 4'b0000;
  localparam logic [3:0] R_START = 4'b0001;
  localparam logic [3:0] R_PAUSE = 4'b0010;
  localparam logic [3:0] R_STOP  = 4'b0100;
  localparam logic [3:0] R_RST   = 4'b1000;

  localparam int M_IDLE = 0, M_ARM = 1, M_REC = 2, M_PAUSE = 3, M_DONE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, lrc, dat, start, pause, stop;
  logic [1:0]    chan;
  logic          we, busy, done;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [AW:0]   len;

  aud_recorder_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_lrc     (lrc),
    .i_data    (dat),
    .i_start   (start),
    .i_pause   (pause),
    .i_stop    (stop),
    .i_chan    (chan),
    .o_we      (we),
    .o_address (addr),
    .o_data    (data),
    .o_len     (len),
    .o_busy    (busy),
    .o_done    (done)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int            m_state, m_mode, m_ptr, m_last_addr;
  bit            m_stop_p, m_pause_p;
  logic [DW-1:0] m_last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rlen();
    return int'($urandom_range(DW + 5, DW + 2));
  endfunction

  task automatic m_reset();
    m_state = M_IDLE; m_mode = 0; m_ptr = 0; m_last_addr = 0;
    m_last_data = '0; m_stop_p = 0; m_pause_p = 0;
  endtask

  // Requests only become state changes at the start of a left slot.
  task automatic m_boundary();
    if (m_state == M_ARM || m_state == M_REC) begin
      m_state   = m_stop_p ? M_DONE : (m_pause_p ? M_PAUSE : M_REC);
      m_stop_p  = 0;
      m_pause_p = 0;
    end
  endtask

  task automatic m_request(input bit s_stop, input bit s_pause, input bit s_start);
    case (m_state)
      M_IDLE, M_DONE: if (s_start) begin
        m_state = M_ARM; m_ptr = 0; m_stop_p = 0; m_pause_p = 0;
        m_mode  = (chan == 2'd1) ? 1 : ((chan == 2'd2) ? 2 : 0);
      end
      M_ARM, M_REC: begin
        if (s_stop)  m_stop_p  = 1;
        if (s_pause) m_pause_p = 1;
      end
      M_PAUSE: begin
        if (s_stop)       m_state = M_DONE;
        else if (s_start) m_state = M_ARM;
      end
      default: ;
    endcase
  endtask

  function automatic bit m_slot_on(input bit l);
    return (m_state == M_REC) && (m_ptr < (1 << AW)) &&
           ((m_mode == 2) || ((m_mode == 1) ? l : !l));
  endfunction

  task automatic send_slot(input bit l, input logic [DW-1:0] w, input int slen,
                           input int rpos, input logic [3:0] req);
    for (int j = 0; j < slen; j++) begin
      bit exp_we;
      lrc = l;
      dat = (j >= 1 && j <= DW) ? w[DW-j] : 1'($urandom);
      {rst, stop, pause, start} = (j == rpos) ? req : R_NONE;
      if (j == 0 && !l) m_boundary();
      exp_we = (j == DW) && m_slot_on(l);
      @(posedge clk); #1;
      chk("we", 64'(we), 64'(exp_we));
      if (exp_we) begin
        chk("addr_at_we", 64'(addr), 64'(m_ptr));
        chk("data_at_we", 64'(data), 64'(w));
        chk("len_at_we", 64'(len), 64'(m_ptr + 1));
        m_last_addr = m_ptr;
        m_last_data = w;
        m_ptr++;
        if (m_ptr == (1 << AW)) begin
          m_state = M_DONE; m_stop_p = 0; m_pause_p = 0;
        end
      end
      if (j == rpos) begin
        if (req[3]) m_reset();
        else        m_request(req[2], req[1], req[0]);
      end
    end
    {rst, stop, pause, start} = R_NONE;
    chk("busy", 64'(busy), 64'(m_state == M_ARM || m_state == M_REC));
    chk("done", 64'(done), 64'(m_state == M_DONE));
    chk("len", 64'(len), 64'(m_ptr));
    chk("addr_held", 64'(addr), 64'(m_last_addr));
    chk("data_held", 64'(data), 64'(m_last_data));
  endtask

  task automatic frame(input logic [DW-1:0] wl, input logic [DW-1:0] wr,
                       input logic [3:0] rql, input logic [3:0] rqr, input int lenl);
    send_slot(1'b0, wl, lenl, 2, rql);
    send_slot(1'b1, wr, rlen(), 2, rqr);
  endtask

  function automatic logic [DW-1:0] rw();
    return DW'($urandom);
  endfunction

  initial begin
    rst = 1'b1; lrc = 1'b1; dat = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    chan = 2'd0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_len", 64'(len), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    send_slot(1'b1, rw(), DW + 2, -1, R_NONE);

    // Mono left: right slots carry 0xFFFF and must never be stored.
    chan = 2'd0;
    frame(rw(), rw(), R_START, R_NONE, rlen());
    frame(16'hA5C3, 16'hFFFF, R_NONE, R_NONE, rlen());
    frame(16'h1234, 16'hFFFF, R_NONE, R_NONE, rlen());
    chk("mono_len", 64'(len), 64'd2);
    chk("mono_last", 64'(data), 64'h1234);
    frame(rw(), rw(), R_STOP, R_NONE, rlen());
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    chk("mono_stop_done", 64'(done), 64'd1);

    // Stereo, pause mid-left, resume, fill to capacity, restart.
    chan = 2'd2;
    frame(rw(), rw(), R_START, R_NONE, rlen());
    frame(16'h8001, 16'h7FFE, R_NONE, R_NONE, rlen());
    frame(rw(), rw(), R_PAUSE, R_NONE, rlen());
    chk("pause_pair_len", 64'(len), 64'd4);
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    chk("paused_busy", 64'(busy), 64'd0);
    frame(rw(), rw(), R_START, R_NONE, rlen());
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    chk("full_done", 64'(done), 64'd1);
    chk("full_len", 64'(len), 64'd8);
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    frame(rw(), rw(), R_START, R_NONE, rlen());
    for (int f = 0; f < 4; f++) frame(rw(), rw(), R_NONE, R_NONE, rlen());
    chk("cont_addr", 64'(addr), 64'd7);
    chk("cont_len", 64'(len), 64'd8);

    // Short left slot is discarded; the next full slot lands at the same address.
    chan = 2'd3;
    frame(rw(), rw(), R_START, R_NONE, rlen());
    frame(rw(), rw(), R_NONE, R_NONE, 11);
    chk("short_len", 64'(len), 64'd0);
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    chk("after_short_len", 64'(len), 64'd1);

    // Reset mid-word while recording at address 5.
    chan = 2'd2;
    frame(rw(), rw(), R_STOP, R_NONE, rlen());
    frame(rw(), rw(), R_START, R_NONE, rlen());
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    send_slot(1'b0, rw(), rlen(), -1, R_NONE);
    chk("pre_rst_len", 64'(len), 64'd5);
    send_slot(1'b1, rw(), rlen(), 5, R_RST);
    chk("post_rst_addr", 64'(addr), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    frame(rw(), rw(), R_NONE, R_NONE, rlen());

    // Stop, pause and start together while recording: stop wins at the boundary.
    chan = 2'd1;
    frame(rw(), rw(), R_START, R_NONE, rlen());
    frame(rw(), rw(), R_STOP | R_PAUSE | R_START, R_NONE, rlen());
    frame(rw(), rw(), R_NONE, R_NONE, rlen());
    chk("combo_done", 64'(done), 64'd1);
    chk("combo_len", 64'(len), 64'd1);

    // Randomized traffic against the model.
    for (int f = 0; f < 40; f++) begin
      logic [3:0] rq [2];
      for (int s = 0; s < 2; s++) begin
        case ($urandom_range(9, 0))
          0, 1:    rq[s] = R_START;
          2:       rq[s] = R_PAUSE;
          3:       rq[s] = R_STOP;
          4:       rq[s] = 4'($urandom_range(7, 1));
          5:       rq[s] = ($urandom_range(3, 0) == 0) ? R_RST : R_NONE;
          default: rq[s] = R_NONE;
        endcase
      end
      chan = 2'($urandom);
      frame(rw(), rw(), rq[0], rq[1], ($urandom_range(4, 0) == 0) ? 11 : rlen());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
